seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (min 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only when ready=1.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned dividend, captured on an accepted start.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned divisor, captured on an accepted start.
REQ-007 SHALL have port ready, output, 1 bit: high in IDLE only.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 SHALL have port quotient, output, WIDTH bits: registered quotient.
REQ-010 SHALL have port remainder, output, WIDTH bits: registered remainder.
REQ-011 SHALL have port div_by_zero, output, 1 bit: flag for the last completed operation.

Function
REQ-012 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-013 IDLE SHALL go to BUSY when start=1 and divisor!=0; operands latched that edge; counter loaded with WIDTH.
REQ-014 IDLE SHALL go to DONE when start=1 and divisor==0; no BUSY cycles are spent.
REQ-015 BUSY SHALL perform one restoring step per cycle:
- partial remainder (WIDTH+1 bits) shifted left, bringing in the next dividend bit MSB-first;
- trial subtract of the divisor;
- if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-016 BUSY SHALL decrement the counter each cycle and go to DONE after exactly WIDTH steps.
REQ-017 DONE SHALL last exactly one cycle, with done=1 in that cycle, then return to IDLE.
REQ-018 Latency SHALL be fixed: start accepted at edge T gives done=1 in cycle T+WIDTH+1 for divisor!=0, and in cycle T+1 for divisor==0.
REQ-019 quotient, remainder and div_by_zero SHALL update only on the edge entering DONE, and hold until the next DONE.
REQ-020 Divide by zero SHALL produce quotient all-ones, remainder=dividend, div_by_zero=1; otherwise div_by_zero=0.
REQ-021 start while in BUSY or DONE SHALL be ignored; the latched operands SHALL be unaffected by input changes after acceptance.
REQ-022 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor!=0.
REQ-023 ready SHALL be combinationally equal to (state==IDLE); done SHALL be registered or decoded from state, with no glitch path from the inputs.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE from any state, including mid-BUSY; an in-flight operation is abandoned and produces no done.
REQ-025 Reset values SHALL be: ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal remainder register=0.
REQ-026 start asserted in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-027 WIDTH=8, dividend=100, divisor=7, start at edge T -> done=1 only in cycle T+9; quotient=14, remainder=2, div_by_zero=0; ready=0 in cycles T+1..T+9.
REQ-028 dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-029 dividend=5, divisor=0 -> done in cycle T+1; quotient=0xFF, remainder=5, div_by_zero=1; the next valid operation clears the flag.
REQ-030 Issue 200/9, pulse start with 50/5 in the third BUSY cycle -> second request ignored; result quotient=22, remainder=2; outputs stable while IDLE.
REQ-031 rst pulsed in the fourth BUSY cycle -> no done pulse; outputs return to reset values; a subsequent 17/4 gives quotient=4, remainder=1.
REQ-032 Random regression, >=10k operands, WIDTH=8 and WIDTH=16 -> REQ-022 identity and REQ-018 latency checked on every result.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, fixed latency,
// divide-by-zero short-circuits straight to the result cycle.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   partRem_q, partRem_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             divByZero_q, divByZero_d;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             qBit;

    // shiftReg starts as the dividend; its MSB feeds the partial remainder
    // and the freshly decided quotient bit enters at its LSB.
    always_comb begin
        shifted     = {partRem_q, shiftReg_q[WIDTH-1]};
        trial       = shifted - {2'b00, divisor_q};
        qBit        = ~trial[WIDTH+1];

        state_d     = state_q;
        count_d     = count_q;
        partRem_d   = partRem_q;
        shiftReg_d  = shiftReg_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d    = BUSY;
                        count_d    = CW'(WIDTH);
                        partRem_d  = '0;
                        shiftReg_d = dividend;
                        divisor_d  = divisor;
                    end else begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        divByZero_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                partRem_d  = qBit ? trial[WIDTH:0] : shifted[WIDTH:0];
                shiftReg_d = {shiftReg_q[WIDTH-2:0], qBit};
                count_d    = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = {shiftReg_q[WIDTH-2:0], qBit};
                    remainder_d = partRem_d[WIDTH-1:0];
                    divByZero_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            partRem_q   <= '0;
            shiftReg_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            partRem_q   <= partRem_d;
            shiftReg_q  <= shiftReg_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;

endmodule
